// File: rtl/pipe_mux_pkg.sv
// Shared types and limits for the registered N:1 selector.
package pipe_mux_pkg;

   // Occupancy of the two-entry output storage.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_mux_state_t;

   // Largest number of data inputs a selector may be built with.
   localparam int PIPE_MUX_MAX_IN = 16;

endpackage : pipe_mux_pkg

// File: rtl/pipe_mux_if.sv
// Handshake bundle for pipe_mux. The input side carries a beat
// (data + select); the output side carries the selected word.
//
// Handshake rule for both sides: a beat moves on a rising edge exactly when
// valid and ready are both high at that edge. A producer holding valid low
// makes its payload don't-care; ready never depends combinationally on the
// valid of the same side.
interface pipe_mux_if #(
   parameter int WIDTH = 16,
   parameter int N_IN  = 2
);
   localparam int SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]      in_sel;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_sel;
   logic                  out_oob;
   logic                  out_valid;
   logic                  out_ready;

   // Upstream/downstream environment side.
   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_oob, out_valid
   );

   // Block side.
   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_oob, out_valid
   );
endinterface : pipe_mux_if

// File: rtl/pipe_mux_sel.sv
// Combinational N:1 selector. An out-of-range select falls to the last
// input, reports that clamped index and raises oob.
module pipe_mux_sel
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N_IN  = 2,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      data,
   output logic [SEL_W-1:0]      sel_applied,
   output logic                  oob
);

   // Default arm is the last input; a matching in-range select overrides it.
   always_comb begin
      data        = in_data[(N_IN-1)*WIDTH +: WIDTH];
      sel_applied = SEL_W'(N_IN-1);
      oob         = 1'b1;
      for (int k = 0; k < N_IN; k++) begin
         if (int'(sel) == k) begin
            data        = in_data[k*WIDTH +: WIDTH];
            sel_applied = SEL_W'(k);
            oob         = 1'b0;
         end
      end
   end

endmodule : pipe_mux_sel

// File: rtl/pipe_mux.sv
// Registered N:1 selector with valid/ready handshake and a one-beat skid.
// The main register drives the outputs; the skid register absorbs the beat
// that arrives in the cycle the downstream stalls, so in_ready can be a pure
// registered decode of the state.
module pipe_mux
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N_IN  = 2,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic            clk,
   input  logic            rst,
   pipe_mux_if.slave       bus,
   output pipe_mux_state_t state
);

   if (N_IN < 2 || N_IN > PIPE_MUX_MAX_IN) begin : g_bad_n_in
      $error("pipe_mux: N_IN out of range 2..%0d", PIPE_MUX_MAX_IN);
   end

   logic [WIDTH-1:0] new_data;
   logic [SEL_W-1:0] new_sel;
   logic             new_oob;

   logic [WIDTH-1:0] main_data, skid_data;
   logic [SEL_W-1:0] main_sel, skid_sel;
   logic             main_oob, skid_oob;
   logic             ready_q, valid_q;
   logic             accept, deliver;

   pipe_mux_sel #(
      .WIDTH (WIDTH),
      .N_IN  (N_IN)
   ) u_sel (
      .in_data     (bus.in_data),
      .sel         (bus.in_sel),
      .data        (new_data),
      .sel_applied (new_sel),
      .oob         (new_oob)
   );

   // Beat transfer events on each side.
   always_comb begin
      accept  = bus.in_valid && ready_q;
      deliver = valid_q && bus.out_ready;
   end

   // Occupancy FSM with the storage it steers; ready/valid are registered
   // alongside the state so they never see out_ready combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         main_data <= '0;
         main_sel  <= '0;
         main_oob  <= 1'b0;
         skid_data <= '0;
         skid_sel  <= '0;
         skid_oob  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_data <= new_data;
                  main_sel  <= new_sel;
                  main_oob  <= new_oob;
                  valid_q   <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (accept && !deliver) begin
                  skid_data <= new_data;
                  skid_sel  <= new_sel;
                  skid_oob  <= new_oob;
                  ready_q   <= 1'b0;
                  state     <= FULL;
               end else if (accept && deliver) begin
                  main_data <= new_data;
                  main_sel  <= new_sel;
                  main_oob  <= new_oob;
               end else if (deliver) begin
                  valid_q   <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               // No accept is possible here because ready_q is low.
               if (deliver) begin
                  main_data <= skid_data;
                  main_sel  <= skid_sel;
                  main_oob  <= skid_oob;
                  ready_q   <= 1'b1;
                  state     <= BUSY;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      bus.in_ready  = ready_q;
      bus.out_valid = valid_q;
      bus.out_data  = main_data;
      bus.out_sel   = main_sel;
      bus.out_oob   = main_oob;
   end

endmodule : pipe_mux

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: directed literal checks plus a randomized run against
// a queue-based model of a two-deep FIFO with select clamping.
module tb_pipe_mux;
   import pipe_mux_pkg::*;

   localparam int W  = 32;
   localparam int N  = 5;
   localparam int SW = $clog2(N);
   localparam int EW = W + SW + 1;

   logic clk;
   logic rst;
   pipe_mux_state_t dbg_state;

   pipe_mux_if #(.WIDTH(W), .N_IN(N)) bus ();

   pipe_mux #(.WIDTH(W), .N_IN(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.slave),
      .state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int acc_cnt = 0;
   int dlv_cnt = 0;

   // Expected {data, sel, oob} for a beat, straight from the select rule.
   function automatic logic [EW-1:0] expect_beat(input logic [N*W-1:0] d, input logic [SW-1:0] s);
      int idx;
      logic [W-1:0] word;
      logic oob;
      oob  = (int'(s) >= N);
      idx  = oob ? N - 1 : int'(s);
      word = d[idx*W +: W];
      return {word, SW'(idx), oob};
   endfunction

   // The block behaves as a two-deep FIFO whose head is shown on the outputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         logic do_acc, do_dlv;
         do_acc = bus.in_valid && (exp_q.size() < 2);
         do_dlv = (exp_q.size() > 0) && bus.out_ready;
         if (do_dlv) begin
            void'(exp_q.pop_front());
            dlv_cnt++;
         end
         if (do_acc) begin
            exp_q.push_back(expect_beat(bus.in_data, bus.in_sel));
            acc_cnt++;
         end
      end
   end

   // Every-cycle compare against the model, plus hold-under-stall check.
   logic          stall_prev = 1'b0;
   logic [EW-1:0] out_prev;
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
         check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
         if (exp_q.size() > 0)
            check("out_beat", 64'({bus.out_data, bus.out_sel, bus.out_oob}), 64'(exp_q[0]));
         if (stall_prev)
            check("stall_hold", 64'({bus.out_data, bus.out_sel, bus.out_oob}), 64'(out_prev));
         stall_prev = bus.out_valid && !bus.out_ready;
         out_prev   = {bus.out_data, bus.out_sel, bus.out_oob};
      end else begin
         stall_prev = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic v, input int s, input logic r);
      bus.in_valid  = v;
      bus.in_sel    = SW'(s);
      bus.out_ready = r;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sel    = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset values.
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(EMPTY));
      step();
      rst = 1'b0;

      // Streaming, one beat per clock.
      bus.in_data = {32'h5555, 32'h4444, 32'h3333, 32'h2222, 32'h1111};
      set_inputs(1'b1, 2, 1'b1);
      step();
      set_inputs(1'b1, 0, 1'b1);
      @(negedge clk);
      check("stream0", 64'(bus.out_data), 64'h3333);
      step();
      set_inputs(1'b1, 3, 1'b1);
      @(negedge clk);
      check("stream1", 64'(bus.out_data), 64'h1111);
      step();
      set_inputs(1'b0, 0, 1'b1);
      @(negedge clk);
      check("stream2", 64'(bus.out_data), 64'h4444);
      check("stream2_valid", 64'(bus.out_valid), 64'd1);
      step();
      @(negedge clk);
      check("stream_empty", 64'(bus.out_valid), 64'd0);

      // Back-pressure: two beats absorbed, then in_ready drops.
      set_inputs(1'b1, 1, 1'b0);
      step();
      set_inputs(1'b1, 4, 1'b0);
      step();
      set_inputs(1'b1, 0, 1'b0);
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_head", 64'(bus.out_data), 64'h2222);
      step();
      @(negedge clk);
      check("bp_still_full", 64'(bus.in_ready), 64'd0);
      set_inputs(1'b0, 0, 1'b1);
      step();
      @(negedge clk);
      check("bp_drain1", 64'(bus.out_data), 64'h5555);
      step();
      @(negedge clk);
      check("bp_drained", 64'(bus.out_valid), 64'd0);

      // Out-of-range select clamps to the last input.
      bus.in_data = {32'hBEEF, 32'h4444, 32'h3333, 32'h2222, 32'h1111};
      set_inputs(1'b1, 6, 1'b1);
      step();
      set_inputs(1'b1, 0, 1'b1);
      @(negedge clk);
      check("oob_data", 64'(bus.out_data), 64'hBEEF);
      check("oob_sel", 64'(bus.out_sel), 64'd4);
      check("oob_flag", 64'(bus.out_oob), 64'd1);
      step();
      set_inputs(1'b1, 4, 1'b1);
      @(negedge clk);
      check("inrange_oob", 64'(bus.out_oob), 64'd0);
      check("inrange_data", 64'(bus.out_data), 64'h1111);
      step();
      set_inputs(1'b0, 0, 1'b1);
      @(negedge clk);
      check("last_in_oob", 64'(bus.out_oob), 64'd0);
      check("last_in_sel", 64'(bus.out_sel), 64'd4);
      step();

      // Asynchronous reset while FULL.
      set_inputs(1'b1, 6, 1'b0);
      step();
      set_inputs(1'b1, 6, 1'b0);
      step();
      set_inputs(1'b0, 0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_out_data", 64'(bus.out_data), 64'd0);
      check("arst_out_oob", 64'(bus.out_oob), 64'd0);
      check("arst_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      rst = 1'b0;
      set_inputs(1'b1, 1, 1'b1);
      step();
      set_inputs(1'b0, 0, 1'b1);
      @(negedge clk);
      check("post_rst_beat", 64'(bus.out_data), 64'h2222);
      step();

      // Randomized run.
      acc_cnt = 0;
      cyc = 0;
      while (acc_cnt < 10000 && cyc < 60000) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_sel    = SW'($urandom_range(0, 7));
         for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = $urandom;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
         cyc++;
      end
      check("random_budget", 64'(acc_cnt >= 10000), 64'd1);

      // Drain what is left.
      set_inputs(1'b0, 0, 1'b1);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         step();
         cyc++;
      end
      step();
      @(negedge clk);
      check("drain_empty", 64'(bus.out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_mux

// File: doc/pipe_mux.md
# pipe_mux

Parametrised, registered N:1 data selector with a valid/ready handshake and a two-entry skid buffer. It is the successor to the processor's 16-bit 2:1 combinational mux, for paths that need selection plus a pipeline register and back-pressure, such as operand select feeding the ALU stage. Selection happens on the input beat and the chosen word is registered. Full throughput is one beat per clock under continuous `out_ready`.

## Interface
- `WIDTH`, 16: data width of each input and of the output.
- `N_IN`, 2: number of data inputs; legal range 2..16.
- `SEL_W`, `$clog2(N_IN)`: select width; derived localparam, not overridable.

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_data`  in  N_IN*WIDTH: flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- `in_sel`  in  SEL_W: input select, sampled with the beat.
- `in_valid`  in  1: upstream beat valid.
- `in_ready`  out  1: block can accept a beat.
- `out_data`  out  WIDTH: selected, registered word.
- `out_sel`  out  SEL_W: select value actually applied, after clamping.
- `out_oob`  out  1: this output beat had an out-of-range select.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: downstream accepts the beat.

## Operation
- Beat accepted when `in_valid && in_ready`; delivered when `out_valid && out_ready`.
- Select rule: `in_sel < N_IN` picks input `in_sel`. Any other value picks input `N_IN-1` (default arm), sets `out_sel = N_IN-1` and sets `out_oob = 1` for that beat only.
- Storage: main register drives the outputs; skid register holds one extra beat. Each entry stores {data, sel, oob}.
- State machine (encoding in package):
  - EMPTY: accept moves the beat to main, go to BUSY.
  - BUSY, accept without deliver: the new beat goes to skid, go to FULL.
  - BUSY, accept with deliver: main is replaced, stay in BUSY.
  - BUSY, deliver without accept: go to EMPTY.
  - BUSY, no event: stay in BUSY.
  - FULL, deliver: skid moves to main, go to BUSY.
  - FULL, no deliver: hold.
- `in_ready` = (state != FULL). It is a registered decode and has no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY).
- Ordering is strict FIFO: beats are never dropped, duplicated or reordered.
- Inputs are ignored when `in_valid = 0`; `in_sel` and `in_data` may be X then.

## Timing
- Latency: accept at edge t makes the beat visible on the outputs after edge t, so it is deliverable in cycle t+1.
- Throughput: 1 beat/clk with `out_ready` held high; the block stays in BUSY.
- Stall: if `out_ready` drops, at most one further beat is absorbed (FULL), then `in_ready = 0` starting the next cycle.
- Simultaneous accept and deliver in FULL cannot occur, because `in_ready = 0` in FULL.
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_sel` and `out_oob` hold.
- Reset, applied at any time including mid-transfer, forces asynchronously:
  - state = EMPTY;
  - `out_valid = 0`, `in_ready = 1`;
  - `out_data = 0`, `out_sel = 0`, `out_oob = 0`;
  - skid contents = 0.
  - In-flight beats are discarded.
- Deassertion is synchronised externally. The first accept is possible at the first edge after `rst` falls.

## Structure
- `pipe_mux_pkg`:
  - `typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_mux_state_t`;
  - `PIPE_MUX_MAX_IN = 16` constant, checked by an elaboration-time assertion on `N_IN`.
- Sub-module `pipe_mux_sel`: purely combinational N:1 selector with default-arm clamp. It outputs {data, sel, oob} and is reused by other datapath selectors.
- Top level holds only the two-entry storage, the FSM and the handshake.

## Test plan
- Reset then streaming: WIDTH=16, N_IN=4, inputs 0x1111/0x2222/0x3333/0x4444, `in_sel` = 2,0,3, `out_ready = 1` -> `out_data` = 0x3333, 0x1111, 0x4444 on consecutive cycles, first one cycle after accept.
- Back-pressure: `out_ready = 0` for 3 cycles with `in_valid` high -> exactly two beats held and `in_ready = 0` from the third cycle. On release, both beats drain in order with no loss.
- Out-of-range: N_IN=3, `in_sel = 3` with input2 = 0xBEEF -> `out_data = 0xBEEF`, `out_sel = 2`, `out_oob = 1` for that beat only. The next beat with `in_sel = 0` gives `out_oob = 0`.
- Reset mid-operation: assert `rst` in FULL -> `out_valid`, `out_data` and `out_oob` are 0 and `in_ready = 1` immediately, before the next edge. The next accepted beat is the next one output.
- Random: random valid/ready patterns, 10k beats, N_IN=5, WIDTH=32 -> a scoreboard matches order and data exactly, and `out_data` is stable under stall.
